// File: rtl/fb_pkg.sv
// Shared types and default geometry for the 1-bpp framebuffer pixel packer.
package fb_pkg;
  localparam int FB_WORD_W   = 32;
  localparam int FB_ADDR_W   = 15;
  localparam int FB_H_PIXELS = 640;
  localparam int FB_V_LINES  = 480;
  localparam int FB_N_WORDS  = FB_H_PIXELS * FB_V_LINES / FB_WORD_W;

  typedef enum logic [1:0] {IDLE, PACK, CLEAR} state_t;
  typedef logic [FB_WORD_W-1:0] word_t;
  typedef logic [FB_ADDR_W-1:0] waddr_t;
endpackage

// File: rtl/fb_word_shifter.sv
// Bit-insert register: pixel k lands at bit k; flags the cycle a 32-pixel word completes.
// Exposes bit_idx only when FB_PIXEL_PACKER_ERR_EN is defined.
module fb_word_shifter import fb_pkg::*; (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       load,
  input  logic       start,
  input  logic       pix,
  output logic       complete,
  output word_t      word
`ifdef FB_PIXEL_PACKER_ERR_EN
  ,
  output logic [4:0] bit_idx_o
`endif
);
  word_t      shreg;
  logic [4:0] bit_idx;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shreg   <= '0;
      bit_idx <= '0;
    end else if (flush) begin
      shreg   <= '0;
      bit_idx <= '0;
    end else if (load) begin
      if (start) begin
        shreg   <= word_t'(pix);
        bit_idx <= 5'd1;
      end else begin
        shreg[bit_idx] <= pix;
        bit_idx        <= bit_idx + 5'd1;
      end
    end
  end

  // The completed word is formed combinationally so the top can register it
  // on the same edge that accepts bit 31.
  assign complete = load && !start && (bit_idx == 5'd31);
  assign word     = {pix, shreg[30:0]};

`ifdef FB_PIXEL_PACKER_ERR_EN
  assign bit_idx_o = bit_idx;
`endif
endmodule

// File: rtl/fb_pixel_packer.sv
// Packs a raster stream of 1-bit pixels into 32-bit framebuffer writes; includes a clear engine.
// Optional truncated-frame counters enabled by FB_PIXEL_PACKER_ERR_EN.
module fb_pixel_packer import fb_pkg::*; #(
  parameter int H_PIXELS = FB_H_PIXELS,
  parameter int V_LINES  = FB_V_LINES,
  parameter int WORD_W   = FB_WORD_W,
  parameter int ADDR_W   = FB_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_valid,
  input  logic              pix_data,
  input  logic              pix_sof,
  output logic              pix_ready,
  input  logic              clear_req,
  input  logic              clear_val,
  output logic [WORD_W-1:0] writedata,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  output logic              busy,
  output logic              frame_done,
  output logic              clear_done
`ifdef FB_PIXEL_PACKER_ERR_EN
  ,
  output logic              sof_err,
  output logic [7:0]        sof_err_cnt
`endif
);
  localparam int          N_WORDS  = H_PIXELS * V_LINES / WORD_W;
  localparam logic [13:0] LAST_IDX = 14'(N_WORDS - 1);

  state_t      state, state_n;
  logic [13:0] word_idx;
  logic        accept, sof_acc, load, clear_start, complete;
  word_t       word;

  assign pix_ready   = (state != CLEAR) && !clear_req;
  assign accept      = pix_valid && pix_ready;
  assign sof_acc     = accept && pix_sof;
  assign load        = accept && ((state == PACK) || pix_sof);
  assign clear_start = clear_req && (state != CLEAR);
  assign busy        = (state != IDLE);

`ifdef FB_PIXEL_PACKER_ERR_EN
  logic [4:0] bit_idx;
`endif

  fb_word_shifter u_shifter (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (clear_start),
    .load     (load),
    .start    (pix_sof),
    .pix      (pix_data),
    .complete (complete),
    .word     (word)
`ifdef FB_PIXEL_PACKER_ERR_EN
    ,
    .bit_idx_o(bit_idx)
`endif
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (clear_req) state_n = CLEAR;
               else if (sof_acc) state_n = PACK;
      PACK:    if (clear_req) state_n = CLEAR;
               else if (complete && word_idx == LAST_IDX) state_n = IDLE;
      CLEAR:   if (word_idx == LAST_IDX) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Clear word 0 issues on the entry edge; writedata then holds the fill
  // pattern for the remainder of the clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      write      <= 1'b0;
      frame_done <= 1'b0;
      clear_done <= 1'b0;
      writedata  <= '0;
      address    <= '0;
      word_idx   <= '0;
    end else begin
      write      <= 1'b0;
      frame_done <= 1'b0;
      clear_done <= 1'b0;
      if (clear_start) begin
        write     <= 1'b1;
        writedata <= {WORD_W{clear_val}};
        address   <= '0;
        word_idx  <= 14'd1;
      end else if (state == CLEAR) begin
        write   <= 1'b1;
        address <= ADDR_W'(word_idx);
        if (word_idx == LAST_IDX) begin
          clear_done <= 1'b1;
          word_idx   <= '0;
        end else begin
          word_idx <= word_idx + 14'd1;
        end
      end else if (sof_acc) begin
        word_idx <= '0;
      end else if (complete) begin
        write     <= 1'b1;
        writedata <= word;
        address   <= ADDR_W'(word_idx);
        if (word_idx == LAST_IDX) begin
          frame_done <= 1'b1;
          word_idx   <= '0;
        end else begin
          word_idx <= word_idx + 14'd1;
        end
      end
    end
  end

`ifdef FB_PIXEL_PACKER_ERR_EN
  // A sof anywhere but the very first pixel slot means the previous frame was cut short.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sof_err     <= 1'b0;
      sof_err_cnt <= '0;
    end else if (sof_acc && state == PACK && (word_idx != '0 || bit_idx != '0)) begin
      sof_err <= 1'b1;
      if (sof_err_cnt != 8'hFF) sof_err_cnt <= sof_err_cnt + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fb_pixel_packer.sv
// Scoreboard bench for fb_pixel_packer on a reduced 64x8 frame (16 words).
module tb_fb_pixel_packer;
  localparam int H = 64;
  localparam int V = 8;
  localparam int N = H * V / 32;

  logic        clk = 1'b0;
  logic        reset_n, pix_valid, pix_data, pix_sof, clear_req, clear_val;
  logic        pix_ready, write, busy, frame_done, clear_done;
  logic [31:0] writedata;
  logic [14:0] address;
`ifdef FB_PIXEL_PACKER_ERR_EN
  logic        sof_err;
  logic [7:0]  sof_err_cnt;
`endif

  fb_pixel_packer #(.H_PIXELS(H), .V_LINES(V), .WORD_W(32), .ADDR_W(15)) dut (
    .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_ready(pix_ready), .clear_req(clear_req),
    .clear_val(clear_val), .writedata(writedata), .write(write),
    .address(address), .busy(busy), .frame_done(frame_done), .clear_done(clear_done)
`ifdef FB_PIXEL_PACKER_ERR_EN
    , .sof_err(sof_err), .sof_err_cnt(sof_err_cnt)
`endif
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [14:0] addr;
    logic [31:0] data;
    logic        fd;
    logic        cd;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  bit          m_active = 0;
  int          m_bit = 0;
  int          m_widx = 0;
  logic [31:0] m_word = '0;

  // Every observed write must match the head of the expected queue, in order.
  always @(negedge clk) begin
    if (reset_n && write) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%0d data=%h", address, writedata);
      end else begin
        e = q.pop_front();
        if ({address, writedata, frame_done, clear_done} !== {e.addr, e.data, e.fd, e.cd}) begin
          errors++;
          $display("FAIL write got addr=%0d data=%h fd=%b cd=%b, expected addr=%0d data=%h fd=%b cd=%b",
                   address, writedata, frame_done, clear_done, e.addr, e.data, e.fd, e.cd);
        end
      end
    end else if (reset_n && (frame_done || clear_done)) begin
      checks++;
      errors++;
      $display("FAIL done_without_write got fd=%b cd=%b", frame_done, clear_done);
    end
  end

  task automatic send_pix(input logic sof, input logic d);
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_data  = d;
    if (sof) begin
      m_active = 1; m_bit = 0; m_widx = 0; m_word = '0;
    end
    if (m_active) begin
      m_word[m_bit] = d;
      m_bit++;
      if (m_bit == 32) begin
        q.push_back(exp_t'{15'(m_widx), m_word, (m_widx == N - 1), 1'b0});
        m_widx++; m_bit = 0; m_word = '0;
        if (m_widx == N) m_active = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic push_clear(input logic val);
    for (int i = 0; i < N; i++)
      q.push_back(exp_t'{15'(i), {32{val}}, 1'b0, (i == N - 1)});
    m_active = 0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending writes, expected 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({write, frame_done, clear_done, busy, writedata, address} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got wr=%b fd=%b cd=%b busy=%b data=%h addr=%0d, expected all 0",
               write, frame_done, clear_done, busy, writedata, address);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (pix_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b expected 1", pix_ready);
    end
  endtask

  task automatic test_full_frame();
    send_pix(1'b1, 1'b1);
    for (int k = 1; k < N * 32; k++) send_pix(1'b0, (k % 2 == 0));
    pix_valid = 1'b0;
    drain("full_frame");
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL full_frame_idle got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_bit_order();
    send_pix(1'b1, 1'b1);
    for (int k = 1; k < N * 32; k++) send_pix(1'b0, 1'b0);
    pix_valid = 1'b0;
    drain("bit_order");
  endtask

  task automatic test_restart();
    send_pix(1'b1, 1'($urandom));
    for (int k = 1; k < 40; k++) send_pix(1'b0, 1'($urandom));
    send_pix(1'b1, 1'($urandom));
    for (int k = 1; k < N * 32; k++) send_pix(1'b0, 1'($urandom));
    pix_valid = 1'b0;
    drain("restart");
`ifdef FB_PIXEL_PACKER_ERR_EN
    checks++;
    if (sof_err !== 1'b1 || sof_err_cnt !== 8'd1) begin
      errors++; $display("FAIL sof_err got %b/%0d expected 1/1", sof_err, sof_err_cnt);
    end
`endif
  endtask

  task automatic test_clear();
    clear_req = 1'b1; clear_val = 1'b1;
    push_clear(1'b1);
    #1;
    checks++;
    if (pix_ready !== 1'b0) begin
      errors++; $display("FAIL clear_req_ready got %b expected 0", pix_ready);
    end
    @(posedge clk); #1;
    clear_req = 1'b0;
    // Offer sof pixels throughout; none may be accepted while clearing.
    for (int i = 0; i < N - 1; i++) begin
      pix_valid = 1'b1; pix_sof = 1'b1; pix_data = 1'b1;
      #1;
      checks++;
      if (pix_ready !== 1'b0) begin
        errors++; $display("FAIL clear_ready word %0d got %b expected 0", i, pix_ready);
      end
      @(posedge clk); #1;
    end
    pix_valid = 1'b0; pix_sof = 1'b0;
    checks++;
    if (clear_done !== 1'b1 || pix_ready !== 1'b1) begin
      errors++; $display("FAIL clear_end got cd=%b ready=%b expected 1/1", clear_done, pix_ready);
    end
    drain("clear");
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL clear_idle got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_collision();
    send_pix(1'b1, 1'($urandom));
    for (int k = 1; k < 96; k++) send_pix(1'b0, 1'($urandom));
    // Bit 31 of word 2 was accepted on the last edge; clear arrives alongside a pixel.
    clear_req = 1'b1; clear_val = 1'b0;
    pix_valid = 1'b1; pix_sof = 1'b0; pix_data = 1'b1;
    push_clear(1'b0);
    #1;
    checks++;
    if (pix_ready !== 1'b0 || write !== 1'b1 || address !== 15'd2) begin
      errors++; $display("FAIL collision_cycle got ready=%b wr=%b addr=%0d expected 0/1/2",
                         pix_ready, write, address);
    end
    @(posedge clk); #1;
    clear_req = 1'b0; pix_valid = 1'b0;
    checks++;
    if (write !== 1'b1 || address !== 15'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL collision_clear_start got wr=%b addr=%0d busy=%b expected 1/0/1",
                         write, address, busy);
    end
    drain("collision");
  endtask

  task automatic test_reset_mid();
    send_pix(1'b1, 1'b1);
    for (int k = 1; k < 100; k++) send_pix(1'b0, 1'($urandom));
    pix_valid = 1'b0;
    drain("reset_mid_pre");
    reset_n = 1'b0;
    m_active = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    checks++;
    if ({write, frame_done, clear_done, busy, writedata, address} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got wr=%b fd=%b cd=%b busy=%b data=%h addr=%0d, expected all 0",
               write, frame_done, clear_done, busy, writedata, address);
    end
`ifdef FB_PIXEL_PACKER_ERR_EN
    checks++;
    if (sof_err !== 1'b0 || sof_err_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_sof_err got %b/%0d expected 0/0", sof_err, sof_err_cnt);
    end
`endif
    for (int k = 0; k < 40; k++) send_pix(1'b0, 1'b1);
    pix_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_ignore got busy=%b expected 0", busy);
    end
  endtask

  initial begin
    reset_n = 1'b0; pix_valid = 1'b0; pix_data = 1'b0; pix_sof = 1'b0;
    clear_req = 1'b0; clear_val = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_full_frame();
    test_bit_order();
    test_restart();
    test_clear();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
